// File: rtl/timer_slot_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : timer_slot_ctl                                                |
// | Purpose  : Shares one free-running cycle counter among NUM_SLOTS          |
// |            software timers. Each accepted command (START/STOP/READ/CLEAR) |
// |            returns a timestamp or accumulated elapsed cycles one cycle    |
// |            later through a single output register.                        |
// | Ports    : clock, resetn (sync, active-low)                               |
// |            ivalid/oready   - command handshake (opcode[1:0], slot)        |
// |            ovalid/iready   - result handshake (result[CNT_W-1:0])         |
// | Options  : TIMER_SAT_EN - accumulator add saturates at all-ones instead   |
// |            of wrapping modulo 2^CNT_W.                                    |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module timer_slot_ctl #(
  parameter int NUM_SLOTS = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ivalid,
  output logic             oready,
  input  logic [31:0]      opcode,
  input  logic [31:0]      slot,
  output logic             ovalid,
  input  logic             iready,
  output logic [CNT_W-1:0] result
);

  localparam logic [1:0]       OP_START = 2'd0;
  localparam logic [1:0]       OP_STOP  = 2'd1;
  localparam logic [1:0]       OP_READ  = 2'd2;
  localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};

  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     stamp [NUM_SLOTS];
  logic [CNT_W-1:0]     accum [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] run;

  logic                 accept;
  logic                 slot_ok;
  logic [1:0]           op;
  logic [NUM_SLOTS-1:0] sel;
  logic [CNT_W-1:0]     cur_stamp;
  logic [CNT_W-1:0]     cur_accum;
  logic                 cur_run;
  logic [CNT_W-1:0]     elapsed;
  logic [CNT_W-1:0]     run_el;
  logic [CNT_W-1:0]     total;
  logic [CNT_W-1:0]     next_result;
  logic                 unused_opcode_bits;

  assign oready  = !ovalid || iready;
  assign accept  = ivalid && oready;
  assign op      = opcode[1:0];
  assign slot_ok = slot < 32'(NUM_SLOTS);

  // Upper opcode bits carry no meaning.
  assign unused_opcode_bits = ^opcode[31:2];

  // Select the addressed slot by full-width compare so out-of-range slot
  // values never alias onto a real slot.
  always_comb begin
    sel       = '0;
    cur_stamp = '0;
    cur_accum = '0;
    cur_run   = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot == 32'(i)) begin
        sel[i]    = 1'b1;
        cur_stamp = stamp[i];
        cur_accum = accum[i];
        cur_run   = run[i];
      end
    end
  end

  // Modular subtraction keeps one run period correct across a counter wrap.
  assign elapsed = cnt - cur_stamp;
  assign run_el  = cur_run ? elapsed : {CNT_W{1'b0}};

`ifdef TIMER_SAT_EN
  logic [CNT_W:0] raw_sum;
  assign raw_sum = {1'b0, cur_accum} + {1'b0, run_el};
  // Once at all-ones any further non-zero add carries, so it stays pinned.
  assign total   = raw_sum[CNT_W] ? ALL_ONES : raw_sum[CNT_W-1:0];
`else
  assign total   = cur_accum + run_el;
`endif

  // STOP on an idle slot and READ share the same sum: run_el is zero when idle.
  always_comb begin
    next_result = '0;
    if (!slot_ok) begin
      next_result = ALL_ONES;
    end else begin
      case (op)
        OP_START: next_result = cnt;
        OP_STOP:  next_result = total;
        OP_READ:  next_result = total;
        default:  next_result = '0;
      endcase
    end
  end

  // Counter and output register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt    <= {{(CNT_W-1){1'b0}}, 1'b1};
      ovalid <= 1'b0;
      result <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (accept) begin
        ovalid <= 1'b1;
        result <= next_result;
      end else if (iready) begin
        ovalid <= 1'b0;
      end
    end
  end

  // Slot state. Updates land on the same edge the result is registered, so
  // a following command to the same slot sees the new state with no bubble.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        stamp[i] <= '0;
        accum[i] <= '0;
      end
      run <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (sel[i]) begin
          case (op)
            OP_START: begin
              if (!run[i]) begin
                stamp[i] <= cnt;
                run[i]   <= 1'b1;
              end
            end
            OP_STOP: begin
              if (run[i]) begin
                accum[i] <= total;
                run[i]   <= 1'b0;
              end
            end
            OP_READ: begin
            end
            default: begin
              accum[i] <= '0;
              run[i]   <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_timer_slot_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_timer_slot_ctl                                             |
// | Purpose  : Self-checking bench for timer_slot_ctl (NUM_SLOTS=4, CNT_W=8) |
// |            with a behavioural reference model and directed checks.       |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_timer_slot_ctl;

  localparam int NS  = 4;
  localparam int W   = 8;
  localparam int MOD = 256;

  logic         clock  = 1'b0;
  logic         resetn = 1'b0;
  logic         ivalid = 1'b0;
  logic         iready = 1'b1;
  logic [31:0]  opcode = '0;
  logic [31:0]  slot   = '0;
  logic         oready;
  logic         ovalid;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state, plain integers modulo 256.
  int m_cnt = 1;
  int m_stamp [NS];
  int m_accum [NS];
  bit m_run   [NS];
  bit m_ovalid = 1'b0;
  int m_result = 0;

  timer_slot_ctl #(.NUM_SLOTS(NS), .CNT_W(W)) dut (
    .clock  (clock),
    .resetn (resetn),
    .ivalid (ivalid),
    .oready (oready),
    .opcode (opcode),
    .slot   (slot),
    .ovalid (ovalid),
    .iready (iready),
    .result (result)
  );

  always #5 clock = ~clock;

  function automatic int madd(input int a, input int b);
    int s;
    s = a + b;
`ifdef TIMER_SAT_EN
    if (s > MOD - 1) return MOD - 1;
`endif
    return s % MOD;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    int now, s, op, el, res;
    if (!resetn) begin
      for (int i = 0; i < NS; i++) begin
        m_stamp[i] = 0;
        m_accum[i] = 0;
        m_run[i]   = 1'b0;
      end
      m_cnt    = 1;
      m_ovalid = 1'b0;
      m_result = 0;
    end else begin
      if (ivalid && (!m_ovalid || iready)) begin
        now = m_cnt;
        op  = int'(opcode[1:0]);
        if (slot >= 32'(NS)) begin
          res = MOD - 1;
        end else begin
          s  = int'(slot);
          el = (now - m_stamp[s] + MOD) % MOD;
          case (op)
            0: begin
              if (!m_run[s]) begin
                m_stamp[s] = now;
                m_run[s]   = 1'b1;
              end
              res = now;
            end
            1: begin
              if (m_run[s]) begin
                m_accum[s] = madd(m_accum[s], el);
                m_run[s]   = 1'b0;
              end
              res = m_accum[s];
            end
            2: res = m_run[s] ? madd(m_accum[s], el) : m_accum[s];
            default: begin
              m_accum[s] = 0;
              m_run[s]   = 1'b0;
              res        = 0;
            end
          endcase
        end
        m_ovalid = 1'b1;
        m_result = res;
      end else if (iready) begin
        m_ovalid = 1'b0;
      end
      m_cnt = (m_cnt + 1) % MOD;
    end
  end

  // Per-cycle comparison against the model; inputs change 2 time units later.
  always @(negedge clock) begin
    if (chk_en) begin
      check("ovalid", 64'(ovalid), 64'(m_ovalid));
      check("oready", 64'(oready), 64'(!m_ovalid || iready));
      if (m_ovalid) check("result", 64'(result), 64'(m_result));
    end
  end

  task automatic step();
    @(negedge clock);
    #2;
  endtask

  task automatic wait_cnt(input int v);
    int n;
    n = 0;
    while (m_cnt != v && n < 300) begin
      step();
      n++;
    end
    if (m_cnt != v) check("wait_cnt_timeout", 64'(m_cnt), 64'(v));
  endtask

  // Issue one command with iready=1; returns at the cycle showing its result.
  task automatic cmd(input int op, input int s);
    ivalid = 1'b1;
    opcode = 32'(op);
    slot   = 32'(s);
    step();
    ivalid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    repeat (3) step();
    check("rst_ovalid", 64'(ovalid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_oready", 64'(oready), 64'd1);
    resetn = 1'b1;
    chk_en = 1'b1;

    // START/STOP/READ on slot 0
    wait_cnt(10);  cmd(0, 0); check("start0", 64'(result), 64'd10);
    wait_cnt(25);  cmd(1, 0); check("stop0",  64'(result), 64'd15);
    cmd(2, 0);                check("read0",  64'(result), 64'd15);

    // READ while running
    wait_cnt(100); cmd(0, 1); check("start1", 64'(result), 64'd100);
    wait_cnt(130); cmd(2, 1); check("read1",  64'(result), 64'd30);
    wait_cnt(140); cmd(1, 1); check("stop1",  64'(result), 64'd40);

    // Backpressure: START at 200 held, READ waits until iready rises at 202
    wait_cnt(200);
    iready = 1'b0;
    ivalid = 1'b1; opcode = 32'd0; slot = 32'd0;
    step();
    check("bp_ovalid", 64'(ovalid), 64'd1);
    check("bp_oready", 64'(oready), 64'd0);
    check("bp_result", 64'(result), 64'd200);
    opcode = 32'd2;
    step();
    check("bp_hold", 64'(result), 64'd200);
    iready = 1'b1;
    step();
    ivalid = 1'b0;
    check("bp_read", 64'(result), 64'd17);

    // Invalid slot and double START
    cmd(2, 7);     check("bad_read",  64'(result), 64'd255);
    cmd(3, 7);     check("bad_clear", 64'(result), 64'd255);
    cmd(2, 1);     check("slot1_kept", 64'(result), 64'd40);
    wait_cnt(50);  cmd(0, 2); check("start2a", 64'(result), 64'd50);
    wait_cnt(60);  cmd(0, 2); check("start2b", 64'(result), 64'd60);
    wait_cnt(70);  cmd(1, 2); check("stop2",   64'(result), 64'd20);

    // Wrap and saturation on slot 3
    wait_cnt(8'hF0); cmd(0, 3); check("wrap_start", 64'(result), 64'h0F0);
    wait_cnt(8'h10); cmd(1, 3); check("wrap_stop",  64'(result), 64'h020);
    cmd(3, 3);                  check("clear3",     64'(result), 64'd0);
    wait_cnt(8'h20); cmd(0, 3);
    wait_cnt(8'h10); cmd(1, 3); check("acc_f0",     64'(result), 64'h0F0);
    wait_cnt(8'h20); cmd(0, 3);
    wait_cnt(8'h40); cmd(1, 3);
`ifdef TIMER_SAT_EN
    check("acc_sat", 64'(result), 64'h0FF);
`else
    check("acc_wrap", 64'(result), 64'h010);
`endif

    // Reset while a result is pending
    iready = 1'b0;
    cmd(0, 0);
    check("pend_ovalid", 64'(ovalid), 64'd1);
    resetn = 1'b0;
    iready = 1'b1;
    step();
    resetn = 1'b1;
    check("mid_rst_ovalid", 64'(ovalid), 64'd0);
    check("mid_rst_result", 64'(result), 64'd0);
    cmd(2, 0); check("post_rst_read",  64'(result), 64'd0);
    cmd(0, 2); check("post_rst_cnt",   64'(result), 64'd2);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      ivalid = ($urandom_range(0, 3) != 0);
      opcode = $urandom;
      slot   = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4));
      iready = ($urandom_range(0, 3) != 0);
      resetn = ($urandom_range(0, 599) != 0);
      step();
    end
    resetn = 1'b1;
    ivalid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_slot_ctl.md
Name: timer_slot_ctl

Overview:
- OpenCL RTL library function that shares one free-running cycle counter among NUM_SLOTS software timers.
- Kernel code issues START / STOP / READ / CLEAR commands per slot through the standard ivalid/oready/ovalid/iready handshake.
- Each command returns a timestamp or the accumulated elapsed cycles for that slot.
- Sits beside the kernel datapath as the profiling controller for the shared counter resource.

Parameters:
- NUM_SLOTS, 4, number of independent timer slots (1..256).
- CNT_W, 32, width of the counter, the start stamps, the accumulators and the result.

Ports:
- clock  input  1  kernel clock.
- resetn  input  1  reset, synchronous, active-low.
- ivalid  input  1  upstream command valid.
- oready  output  1  block can accept a command this cycle.
- opcode  input  32  bits [1:0] select the command: 0=START, 1=STOP, 2=READ, 3=CLEAR. Bits [31:2] are ignored.
- slot  input  32  target slot index.
- ovalid  output  1  result valid.
- iready  input  1  downstream ready for the result.
- result  output  CNT_W  command result.

Behaviour:
- Counter: internal free-running counter, named cnt below.
  - Reset value 1; increments by 1 every cycle after reset.
  - Wraps modulo 2^CNT_W.
- Per-slot state:
  - stamp[CNT_W], accum[CNT_W], run (1 bit).
  - Reset values: stamp=0, accum=0, run=0.
- Handshake:
  - Single output register.
  - oready = !ovalid || iready.
  - A command is accepted when ivalid && oready.
  - ivalid while oready=0 is ignored; the upstream holds it.
- Latency: result appears with ovalid=1 exactly 1 cycle after acceptance.
  - The result is held stable while ovalid && !iready.
  - ovalid falls after iready=1 unless a new command is accepted in the same cycle.
  - Back-to-back throughput is 1 command/cycle while iready=1.
- Timing reference: every command uses cnt as it is in the acceptance cycle, written "now" below.
- Elapsed time: el = now - stamp[s], modulo 2^CNT_W. A single run period is therefore correct across one counter wrap.
- START:
  - If run=0: stamp=now, run=1.
  - If run=1: no state change.
  - result = now in both cases.
- STOP:
  - If run=1: accum = accum + el, run=0, result = new accum.
  - If run=0: no state change, result = accum.
- READ:
  - No state change.
  - result = accum + (run ? el : 0), using the same add rule as STOP.
- CLEAR: accum=0, run=0, stamp unchanged; result=0.
- Invalid slot (slot >= NUM_SLOTS): no state change; result = all-ones; ovalid is asserted normally.
- Consecutive commands to the same slot: the second command sees the state already updated by the first. No hazard bubble is allowed.
- Reset mid-operation: on any edge with resetn=0, every slot, cnt, ovalid and result clear to their reset values, and any pending result is discarded.
- Reset values of outputs:
  - ovalid=0, result=0.
  - oready=1, since it follows from ovalid=0.

Optional Feature:
- Macro: TIMER_SAT_EN.
- Defined: the accum add in STOP and READ saturates at all-ones (2^CNT_W-1). A saturated accum stays saturated until CLEAR.
- Undefined: the add wraps modulo 2^CNT_W.

Test Plan:
1. START and STOP on one slot:
   - Release reset, wait until cnt=10, START slot0 -> result=10 next cycle.
   - STOP slot0 at cnt=25 -> result=15.
   - READ slot0 -> 15.
2. READ while running:
   - START slot1 at cnt=100, READ slot1 at cnt=130 -> result=30, run still 1.
   - STOP slot1 at cnt=140 -> result=40.
3. Backpressure:
   - Hold iready=0 after a START result -> ovalid=1, result held, oready=0.
   - A second ivalid is not accepted.
   - Raise iready -> the second command is accepted in that same cycle, and its result follows 1 cycle later.
4. Invalid slot and double START, with NUM_SLOTS=4:
   - Any command to slot=7 -> result=all-ones; slots 0-3 are unchanged.
   - START slot2 twice at cnt=50 and cnt=60 -> results 50, 60; stamp stays 50.
5. Wrap and saturation, with CNT_W=8:
   - START at cnt=0xF0, STOP at cnt=0x10 -> result=0x20.
   - Accumulate 0xF0 and then 0x20 on one slot:
     - with TIMER_SAT_EN -> 0xFF;
     - without TIMER_SAT_EN -> 0x10.
6. Reset mid-op:
   - START slot0, assert resetn=0 for 1 cycle while a result is pending -> ovalid=0, result=0.
   - READ slot0 after reset -> 0.
   - cnt restarts at 1.
